// File: rtl/int_square_pkg.sv
// Shared constants for the sequential squarer.
// State encodings match the integer square-root block so the two can share decode logic.
package int_square_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned STATE_W       = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
    localparam logic [STATE_W-1:0] ST_MUL  = 2'b01;
    localparam logic [STATE_W-1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/int_square_if.sv
// start/done_stb handshake bundle for the squarer.
// The master side issues operands; the slave side is the squarer.
interface int_square_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     n;
    logic                 busy;
    logic                 done_stb;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start,
        output n,
        input  busy,
        input  done_stb,
        input  result
    );

    modport slave (
        input  start,
        input  n,
        output busy,
        output done_stb,
        output result
    );
endinterface

// File: rtl/int_square.sv
// Sequential integer squarer: result = n*n by shift-and-add, one multiplier bit per cycle.
// Fixed latency of WIDTH+1 cycles from accept to done_stb.
module int_square
    import int_square_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    int_square_if.slave  bus
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [RES_W-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_stb_q, done_stb_d;
    logic [RES_W-1:0]   result_q, result_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplr_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_stb_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplr_q     <= mplr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_stb_q <= done_stb_d;
            result_q   <= result_d;
        end
    end

    // Next-state and add/shift step
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_stb_d = 1'b0;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    acc_d   = '0;
                    mcand_d = {{WIDTH{1'b0}}, bus.n};
                    mplr_d  = bus.n;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                // No early exit when mplr drains to zero: latency stays fixed.
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_d   = acc_q;
                done_stb_d = 1'b1;
                busy_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done_stb = done_stb_q;
    assign bus.result   = result_q;

endmodule

// File: tb/tb_int_square.sv
// Scoreboard bench for int_square: directed operands with hand-computed squares,
// a monitor pops expected {result, done cycle} on every done_stb.
module tb_int_square;

    localparam int unsigned W = 16;

    typedef struct {
        logic [2*W-1:0] res;
        int             cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passes;
    exp_t sb_q[$];
    logic [2*W-1:0] last_res;

    int_square_if #(.WIDTH(W)) bus ();

    int_square #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every done_stb must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done_stb === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done_stb: got pulse with result %0d expected no pulse (cycle %0d)",
                         bus.result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 64'(bus.result), 64'(e.res));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic wait_done(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.done_stb === 1'b1) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // Single-cycle start pulse; checks busy span, result hold, and busy drop afterwards
    task automatic run_op(input logic [W-1:0] v, input logic [2*W-1:0] exp);
        int  busy_n;
        bit  seen;
        exp_t e;
        @(posedge clk); #1;
        bus.n     = v;
        bus.start = 1'b1;
        e.res = exp;
        e.cyc = cyc + 18;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.n     = ~v;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) check("result_held", 64'(bus.result), 64'(last_res));
            if (bus.done_stb === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) busy_n++;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(busy_n), 64'd17);
        last_res = exp;
        @(negedge clk);
        check("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        exp_t e;
        checks    = 0;
        passes    = 0;
        last_res  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.n     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done_stb), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic operands including zero and the full-width carry case
        run_op(16'd0,     32'd0);
        run_op(16'd255,   32'd65025);
        run_op(16'd65535, 32'hFFFE0001);
        run_op(16'd1,     32'd1);
        run_op(16'h8000,  32'h40000000);
        run_op(16'hAAAA,  32'd1908816100);

        // Back-to-back with start held: pulses 18 cycles apart
        @(posedge clk); #1;
        bus.n     = 16'd3;
        bus.start = 1'b1;
        e.res = 32'd9;          e.cyc = cyc + 18; sb_q.push_back(e);
        e.res = 32'd2147395600; e.cyc = cyc + 36; sb_q.push_back(e);
        @(posedge clk); #1;
        bus.n = 16'd46340;
        repeat (18) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("b2b_second_done", 30);
        last_res = 32'd2147395600;
        @(negedge clk);
        check("b2b_busy_after", 64'(bus.busy), 64'd0);

        // Start pulsed mid-operation is ignored
        @(posedge clk); #1;
        bus.n     = 16'd100;
        bus.start = 1'b1;
        e.res = 32'd10000; e.cyc = cyc + 18; sb_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.n     = 16'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("midop_done", 30);
        last_res = 32'd10000;
        repeat (25) @(posedge clk);

        // Asynchronous reset mid-operation discards it
        @(posedge clk); #1;
        bus.n     = 16'd1234;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done_stb), 64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        last_res = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        run_op(16'd12, 32'd144);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
